xoodyak_digest_collector: RTL

XOODYAK_DIGEST_COLLECTOR -- requirements
Module: xoodyak_digest_collector

---
 rtl/xoodyak_digest_collector_pkg.sv | 7 +
 rtl/xoodyak_digest_collector_if.sv | 21 ++
 rtl/xoodyak_byte_shift_reg.sv | 22 ++
 rtl/xoodyak_digest_collector.sv | 97 +++++++++
 4 files changed

// File: rtl/xoodyak_digest_collector_pkg.sv
// xoodyak_digest_collector_pkg: shared FSM encoding and sizing constants for the digest collector
package xoodyak_digest_collector_pkg;
  localparam int BYTE_W = 8;
  localparam int DIGEST_BYTES_DEF = 32;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
endpackage

// File: rtl/xoodyak_digest_collector_if.sv
// xoodyak_digest_collector_if: hash byte stream in, assembled digest out with valid/ready handoff
interface xoodyak_digest_collector_if
  import xoodyak_digest_collector_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF
);
  logic [BYTE_W-1:0] hash_in;
  logic hash_valid;
  logic [7:0] hash_idx;
  logic [BYTE_W*DIGEST_BYTES-1:0] digest;
  logic digest_valid;
  logic digest_ready;
  modport master (
    output hash_in, hash_valid, hash_idx, digest_ready,
    input digest, digest_valid
  );
  modport slave (
    input hash_in, hash_valid, hash_idx, digest_ready,
    output digest, digest_valid
  );
endinterface

// File: rtl/xoodyak_byte_shift_reg.sv
// xoodyak_byte_shift_reg: indexed byte-write register file holding the digest buffer
module xoodyak_byte_shift_reg
  import xoodyak_digest_collector_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic we,
  input  logic [7:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W*DIGEST_BYTES-1:0] data_q,
  output logic [BYTE_W*DIGEST_BYTES-1:0] data_d
);
  for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_slot
    assign data_d[i*BYTE_W +: BYTE_W] = (we && waddr == 8'(i)) ? wdata : data_q[i*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk) begin
    if (!resetn) data_q <= '0;
    else data_q <= data_d;
  end
endmodule

// File: rtl/xoodyak_digest_collector.sv
// xoodyak_digest_collector: assembles hash bytes into a digest held until the consumer takes it.
// Defining XOODYAK_DIGEST_CHECK_EN adds an expected/match comparison against a reference digest.
module xoodyak_digest_collector
  import xoodyak_digest_collector_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  xoodyak_digest_collector_if.slave bus,
  output logic [7:0] byte_cnt,
  output logic seq_err,
  output logic overflow
`ifdef XOODYAK_DIGEST_CHECK_EN
  ,
  input  logic [BYTE_W*DIGEST_BYTES-1:0] expected,
  output logic match
`endif
);
  logic [0:0] state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic digest_valid_q, digest_valid_d;
  logic seq_err_q, seq_err_d;
  logic overflow_q, overflow_d;
  logic accept, last;
  logic [7:0] waddr;
  logic [BYTE_W*DIGEST_BYTES-1:0] digest_q, digest_d;
  // A byte arriving in HOLD together with ready becomes slot 0 of the next digest
  always_comb begin
    accept = bus.hash_valid && !clear && (state_q == COLLECT || bus.digest_ready);
    waddr = (state_q == HOLD) ? 8'd0 : byte_cnt_q;
    last = state_q == COLLECT && byte_cnt_q == 8'(DIGEST_BYTES - 1);
    state_d = state_q;
    byte_cnt_d = byte_cnt_q;
    digest_valid_d = digest_valid_q;
    seq_err_d = seq_err_q || (accept && bus.hash_idx != waddr + 8'd1);
    overflow_d = overflow_q;
    if (clear) begin
      state_d = COLLECT;
      byte_cnt_d = 8'd0;
      digest_valid_d = 1'b0;
      seq_err_d = 1'b0;
      overflow_d = 1'b0;
    end else if (state_q == COLLECT) begin
      if (bus.hash_valid) begin
        state_d = last ? HOLD : COLLECT;
        byte_cnt_d = last ? 8'd0 : byte_cnt_q + 8'd1;
        digest_valid_d = last;
      end
    end else if (bus.digest_ready) begin
      state_d = COLLECT;
      digest_valid_d = 1'b0;
      byte_cnt_d = bus.hash_valid ? 8'd1 : 8'd0;
    end else begin
      overflow_d = overflow_q || bus.hash_valid;
    end
  end
  xoodyak_byte_shift_reg #(.DIGEST_BYTES(DIGEST_BYTES)) u_buf (
    .clk(clk),
    .resetn(resetn),
    .we(accept),
    .waddr(waddr),
    .wdata(bus.hash_in),
    .data_q(digest_q),
    .data_d(digest_d)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= COLLECT;
      byte_cnt_q <= 8'd0;
      digest_valid_q <= 1'b0;
      seq_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_cnt_q <= byte_cnt_d;
      digest_valid_q <= digest_valid_d;
      seq_err_q <= seq_err_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.digest = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign byte_cnt = byte_cnt_q;
  assign seq_err = seq_err_q;
  assign overflow = overflow_q;
`ifdef XOODYAK_DIGEST_CHECK_EN
  logic match_q, match_d;
  always_comb match_d = digest_valid_d && (digest_d == expected);
  always_ff @(posedge clk) begin
    if (!resetn) match_q <= 1'b0;
    else match_q <= match_d;
  end
  assign match = match_q;
`endif
endmodule
